fp_exp_align_norm_pipe: RTL and testbench

//  Parametrised, pipelined exponent datapath for the FP add/sub unit.

---
 rtl/fp_exp_pkg.sv | 21 ++
 rtl/exp_tag_fifo.sv | 63 ++++++
 rtl/fp_exp_align_norm_pipe.sv | 140 ++++++++++++++
 tb/tb_fp_exp_align_norm_pipe.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_exp_pkg.sv
// Shared definitions for the FP add/sub exponent datapath: normalisation
// direction encoding and the alignment-shift helper functions.
package fp_exp_pkg;

   // Direction of the normalisation correction applied to the larger exponent
   typedef enum logic {
      NORM_ADD = 1'b0,
      NORM_SUB = 1'b1
   } norm_dir_e;

   // Largest useful alignment shift: mantissa width plus guard, round and sticky
   function automatic int shift_max(input int man_w);
      return man_w + 3;
   endfunction

   // Clamp an exponent-difference magnitude to the largest useful shift
   function automatic int sat_shift(input int mag, input int smax);
      return (mag > smax) ? smax : mag;
   endfunction

endpackage

// File: rtl/exp_tag_fifo.sv
// Small synchronous FIFO holding the larger exponent of each in-flight op
// until the mantissa path reports its normalisation count.
module exp_tag_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 3
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [W-1:0]               push_data,
   input  logic                       pop,
   output logic [W-1:0]               pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Pointers wrap at DEPTH, which need not be a power of two
   function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   // Storage and pointer/occupancy bookkeeping; simultaneous push and pop keep the count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wrap_inc(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= wrap_inc(rd_ptr);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fp_exp_align_norm_pipe.sv
// Pipelined exponent datapath for the FP add/sub unit. The align side returns
// the exponent difference, swap flag and saturated alignment shift; the norm
// side pairs each returned normalisation count with the queued larger
// exponent and produces the final, saturated exponent.
module fp_exp_align_norm_pipe
   import fp_exp_pkg::*;
#(
   parameter int EXP_W = 3,
   parameter int MAN_W = 4,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         a_valid,
   output logic                         a_ready,
   input  logic [EXP_W-1:0]             exp_a,
   input  logic [EXP_W-1:0]             exp_b,
   output logic                         al_valid,
   input  logic                         al_ready,
   output logic [EXP_W:0]               al_diff,
   output logic                         al_swap,
   output logic [$clog2(MAN_W+4)-1:0]   al_shift,
   input  logic                         n_valid,
   output logic                         n_ready,
   input  logic [EXP_W-1:0]             n_amt,
   input  logic                         n_dir,
   output logic                         y_valid,
   input  logic                         y_ready,
   output logic [EXP_W-1:0]             exp_y,
   output logic                         y_ovf,
   output logic                         y_unf,
   output logic [$clog2(DEPTH+1)-1:0]   pend_cnt
);

   localparam int SHIFT_MAX = shift_max(MAN_W);
   localparam int SH_W      = $clog2(SHIFT_MAX + 1);

   logic             fifo_full;
   logic             fifo_empty;
   logic [EXP_W-1:0] head_exp;
   logic             push;
   logic             pop;

   logic [EXP_W:0]   diff_c;
   logic             swap_c;
   logic [EXP_W-1:0] mag_c;
   logic [EXP_W-1:0] max_c;
   logic [SH_W-1:0]  shift_c;

   logic [EXP_W:0]   sum_c;
   logic [EXP_W:0]   sub_c;
   logic [EXP_W-1:0] res_c;
   logic             ovf_c;
   logic             unf_c;

   // A full FIFO blocks new ops even if the norm side pops this cycle
   assign a_ready = (!al_valid || al_ready) && !fifo_full;
   assign n_ready = !fifo_empty && (!y_valid || y_ready);
   assign push    = a_valid && a_ready;
   assign pop     = n_valid && n_ready;

   // Difference, swap and clamped shift; the larger exponent favours A on a tie
   always_comb begin
      diff_c  = {1'b0, exp_a} - {1'b0, exp_b};
      swap_c  = (exp_a < exp_b);
      mag_c   = swap_c ? (exp_b - exp_a) : (exp_a - exp_b);
      max_c   = swap_c ? exp_b : exp_a;
      shift_c = SH_W'(sat_shift(int'(mag_c), SHIFT_MAX));
   end

   // Align result register: loads on accept, clears once consumed with nothing new behind it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         al_valid <= 1'b0;
         al_diff  <= '0;
         al_swap  <= 1'b0;
         al_shift <= '0;
      end else if (push) begin
         al_valid <= 1'b1;
         al_diff  <= diff_c;
         al_swap  <= swap_c;
         al_shift <= shift_c;
      end else if (al_ready) begin
         al_valid <= 1'b0;
      end
   end

   exp_tag_fifo #(
      .DEPTH (DEPTH),
      .W     (EXP_W)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (max_c),
      .pop       (pop),
      .pop_data  (head_exp),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (pend_cnt)
   );

   // Apply the normalisation count one bit wider so the carry/borrow flags saturation
   always_comb begin
      sum_c = {1'b0, head_exp} + {1'b0, n_amt};
      sub_c = {1'b0, head_exp} - {1'b0, n_amt};
      ovf_c = 1'b0;
      unf_c = 1'b0;
      res_c = sum_c[EXP_W-1:0];
      if (norm_dir_e'(n_dir) == NORM_SUB) begin
         if (sub_c[EXP_W]) begin
            unf_c = 1'b1;
            res_c = '0;
         end else begin
            res_c = sub_c[EXP_W-1:0];
         end
      end else if (sum_c[EXP_W]) begin
         ovf_c = 1'b1;
         res_c = '1;
      end
   end

   // Final exponent register with its saturation flags, held until downstream accepts
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_valid <= 1'b0;
         exp_y   <= '0;
         y_ovf   <= 1'b0;
         y_unf   <= 1'b0;
      end else if (pop) begin
         y_valid <= 1'b1;
         exp_y   <= res_c;
         y_ovf   <= ovf_c;
         y_unf   <= unf_c;
      end else if (y_ready) begin
         y_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fp_exp_align_norm_pipe.sv
// Self-checking bench for fp_exp_align_norm_pipe: directed cases plus random
// traffic scored against a queue-based model of the align/norm behaviour.
module tb_fp_exp_align_norm_pipe;

   localparam int EXP_W = 3;
   localparam int MAN_W = 4;
   localparam int DEPTH = 4;

   logic       clk;
   logic       rst_n;
   logic       a_valid;
   logic       a_ready;
   logic [2:0] exp_a;
   logic [2:0] exp_b;
   logic       al_valid;
   logic       al_ready;
   logic [3:0] al_diff;
   logic       al_swap;
   logic [2:0] al_shift;
   logic       n_valid;
   logic       n_ready;
   logic [2:0] n_amt;
   logic       n_dir;
   logic       y_valid;
   logic       y_ready;
   logic [2:0] exp_y;
   logic       y_ovf;
   logic       y_unf;
   logic [2:0] pend_cnt;

   logic       a2_valid;
   logic       a2_ready;
   logic [2:0] exp_a2;
   logic [2:0] exp_b2;
   logic       al2_valid;
   logic [3:0] al2_diff;
   logic       al2_swap;
   logic [2:0] al2_shift;
   logic       n2_ready;
   logic       y2_valid;
   logic [2:0] exp_y2;
   logic       y2_ovf;
   logic       y2_unf;
   logic [2:0] pend2_cnt;

   int compared;
   int mismatched;

   typedef struct {
      int diff;
      int swap;
      int shift;
   } al_t;

   typedef struct {
      int e;
      int ovf;
      int unf;
   } y_t;

   al_t al_q[$];
   y_t  y_q[$];
   int  ex_q[$];

   fp_exp_align_norm_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .DEPTH(DEPTH)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_ready(a_ready), .exp_a(exp_a), .exp_b(exp_b),
      .al_valid(al_valid), .al_ready(al_ready), .al_diff(al_diff),
      .al_swap(al_swap), .al_shift(al_shift),
      .n_valid(n_valid), .n_ready(n_ready), .n_amt(n_amt), .n_dir(n_dir),
      .y_valid(y_valid), .y_ready(y_ready), .exp_y(exp_y),
      .y_ovf(y_ovf), .y_unf(y_unf), .pend_cnt(pend_cnt)
   );

   fp_exp_align_norm_pipe #(.EXP_W(EXP_W), .MAN_W(2), .DEPTH(DEPTH)) u_dut2 (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a2_valid), .a_ready(a2_ready), .exp_a(exp_a2), .exp_b(exp_b2),
      .al_valid(al2_valid), .al_ready(1'b1), .al_diff(al2_diff),
      .al_swap(al2_swap), .al_shift(al2_shift),
      .n_valid(1'b0), .n_ready(n2_ready), .n_amt(3'd0), .n_dir(1'b0),
      .y_valid(y2_valid), .y_ready(1'b1), .exp_y(exp_y2),
      .y_ovf(y2_ovf), .y_unf(y2_unf), .pend_cnt(pend2_cnt)
   );

   // Free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Reference: align result straight from the arithmetic definition
   function automatic al_t model_align(input int a, input int b, input int man_w);
      al_t r;
      int  d;
      int  mag;
      d       = a - b;
      mag     = (d < 0) ? -d : d;
      r.diff  = d & ((1 << (EXP_W + 1)) - 1);
      r.swap  = (a < b) ? 1 : 0;
      r.shift = (mag > man_w + 3) ? man_w + 3 : mag;
      return r;
   endfunction

   // Reference: final exponent with saturation
   function automatic y_t model_norm(input int h, input int amt, input int dir);
      y_t r;
      int s;
      s     = (dir != 0) ? h - amt : h + amt;
      r.ovf = 0;
      r.unf = 0;
      r.e   = s;
      if (dir == 0 && s > (1 << EXP_W) - 1) begin
         r.e   = (1 << EXP_W) - 1;
         r.ovf = 1;
      end else if (dir != 0 && s < 0) begin
         r.e   = 0;
         r.unf = 1;
      end
      return r;
   endfunction

   // One clock of stimulus on the main DUT, checked against the model
   task automatic applyStimulus(input bit av, input int ea, input int eb, input bit alr,
                                input bit nv, input int amt, input bit dir, input bit yr);
      bit   exp_alv;
      bit   exp_yv;
      bit   exp_ar;
      bit   exp_nr;
      int   h;
      a_valid  = av;
      exp_a    = ea[2:0];
      exp_b    = eb[2:0];
      al_ready = alr;
      n_valid  = nv;
      n_amt    = amt[2:0];
      n_dir    = dir;
      y_ready  = yr;
      #1;
      exp_alv = (al_q.size() != 0);
      exp_yv  = (y_q.size() != 0);
      exp_ar  = (!exp_alv || alr) && (ex_q.size() != DEPTH);
      exp_nr  = (ex_q.size() != 0) && (!exp_yv || yr);
      checkOutput("al_valid", al_valid, exp_alv);
      checkOutput("y_valid", y_valid, exp_yv);
      checkOutput("pend_cnt", pend_cnt, ex_q.size());
      checkOutput("a_ready", a_ready, exp_ar);
      checkOutput("n_ready", n_ready, exp_nr);
      if (exp_alv) begin
         checkOutput("al_diff", al_diff, al_q[0].diff);
         checkOutput("al_swap", al_swap, al_q[0].swap);
         checkOutput("al_shift", al_shift, al_q[0].shift);
      end
      if (exp_yv) begin
         checkOutput("exp_y", exp_y, y_q[0].e);
         checkOutput("y_ovf", y_ovf, y_q[0].ovf);
         checkOutput("y_unf", y_unf, y_q[0].unf);
      end
      if (exp_alv && alr) void'(al_q.pop_front());
      if (exp_yv && yr) void'(y_q.pop_front());
      if (nv && exp_nr) begin
         h = ex_q.pop_front();
         y_q.push_back(model_norm(h, amt & 7, dir));
      end
      if (av && exp_ar) begin
         al_q.push_back(model_align(ea & 7, eb & 7, MAN_W));
         ex_q.push_back(((ea & 7) >= (eb & 7)) ? (ea & 7) : (eb & 7));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      repeat (DEPTH + 3) applyStimulus(0, 0, 0, 1, 1, 0, 0, 1);
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      rst_n      = 1'b0;
      a_valid    = 1'b0;
      exp_a      = '0;
      exp_b      = '0;
      al_ready   = 1'b0;
      n_valid    = 1'b0;
      n_amt      = '0;
      n_dir      = 1'b0;
      y_ready    = 1'b0;
      a2_valid   = 1'b0;
      exp_a2     = '0;
      exp_b2     = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_al_valid", al_valid, 0);
      checkOutput("rst_y_valid", y_valid, 0);
      checkOutput("rst_pend_cnt", pend_cnt, 0);
      checkOutput("rst_al_diff", al_diff, 0);
      checkOutput("rst_al_swap", al_swap, 0);
      checkOutput("rst_al_shift", al_shift, 0);
      checkOutput("rst_exp_y", exp_y, 0);
      checkOutput("rst_flags", {y_ovf, y_unf}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Saturated shift with a narrow mantissa
      a2_valid = 1'b1;
      exp_a2   = 3'd7;
      exp_b2   = 3'd0;
      @(posedge clk);
      #1;
      checkOutput("t4_diff", al2_diff, 7);
      checkOutput("t4_shift", al2_shift, 5);
      checkOutput("t4_swap", al2_swap, 0);
      exp_a2 = 3'd0;
      exp_b2 = 3'd7;
      @(posedge clk);
      #1;
      checkOutput("t4_diff_neg", al2_diff, 4'b1001);
      checkOutput("t4_shift_neg", al2_shift, 5);
      checkOutput("t4_swap_neg", al2_swap, 1);
      a2_valid = 1'b0;

      // Basic add path
      applyStimulus(1, 5, 2, 0, 0, 0, 0, 1);
      checkOutput("t1_diff", al_diff, 4'b0011);
      checkOutput("t1_swap", al_swap, 0);
      checkOutput("t1_shift", al_shift, 3);
      applyStimulus(0, 0, 0, 1, 1, 1, 0, 0);
      checkOutput("t1_exp_y", exp_y, 6);
      checkOutput("t1_flags", {y_ovf, y_unf}, 0);
      drain();

      // Swapped operands, subtract path
      applyStimulus(1, 1, 6, 0, 0, 0, 0, 1);
      checkOutput("t2_diff", al_diff, 4'b1011);
      checkOutput("t2_swap", al_swap, 1);
      checkOutput("t2_shift", al_shift, 5);
      applyStimulus(0, 0, 0, 1, 1, 2, 1, 0);
      checkOutput("t2_exp_y", exp_y, 4);
      drain();

      // Overflow and underflow saturation
      applyStimulus(1, 7, 0, 1, 0, 0, 0, 1);
      applyStimulus(1, 1, 1, 1, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 1, 1, 1, 0, 0);
      checkOutput("t3_ovf_exp", exp_y, 7);
      checkOutput("t3_ovf", {y_ovf, y_unf}, 2'b10);
      applyStimulus(0, 0, 0, 1, 1, 3, 1, 1);
      checkOutput("t3_unf_exp", exp_y, 0);
      checkOutput("t3_unf", {y_ovf, y_unf}, 2'b01);
      drain();

      // Fill the FIFO, then drain in push order
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1, $urandom_range(0, 7), $urandom_range(0, 7), 1, 0, 0, 0, 1);
      end
      checkOutput("t5_pend_full", pend_cnt, 4);
      checkOutput("t5_a_ready_full", a_ready, 0);
      applyStimulus(1, 3, 3, 1, 0, 0, 0, 1);
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(0, 0, 0, 1, 1, 0, 0, 1);
      end
      drain();

      // Back-pressure on both sides holds outputs
      applyStimulus(1, 3, 4, 0, 0, 0, 0, 1);
      applyStimulus(1, 6, 2, 1, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 1, 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 2, 2, 0, 1, 1, 0, 0);
      end
      checkOutput("t6_held_diff", al_diff, 4);
      checkOutput("t6_held_exp_y", exp_y, 5);
      applyStimulus(1, 1, 7, 1, 0, 0, 0, 0);
      checkOutput("t6_pend_two", pend_cnt, 2);

      // Reset mid-operation clears everything at once
      a_valid = 1'b0;
      n_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("t6_rst_al_valid", al_valid, 0);
      checkOutput("t6_rst_y_valid", y_valid, 0);
      checkOutput("t6_rst_pend", pend_cnt, 0);
      al_q.delete();
      y_q.delete();
      ex_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7),
                       ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                       $urandom_range(0, 7), $urandom_range(0, 1),
                       ($urandom_range(0, 3) != 0));
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
